// File: rtl/fetch_pkg.sv
// fetch_pkg: shared reset PC default, nop encoding, FSM state type and prefetch entry type
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fifo_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer of {pc, instr} entries (ports: clk, reset async, push/pop/flush, din, dout=head, empty, full)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fifo_entry_t din,
  output fifo_entry_t dout,
  output logic        empty,
  output logic        full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fifo_entry_t mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign dout = mem[rptr];
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (push && !flush) mem[wptr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(do_pop);
      count <= count + CW'(push) - CW'(do_pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with prefetch FIFO and redirect flush
// Ports: clk, reset (async, active-high); imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata memory side;
// redirect_valid/redirect_target from branch resolution; if_valid/if_instr/if_pc/id_ready to decode;
// perf_fetch_count (consumed-instruction counter) only when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_count
`endif
);
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, out_pc;
  fifo_entry_t head, din;
  logic empty, full, grant, push, pop, outstanding;
  assign outstanding = state != S_REQ;
  // In S_REQ nothing is outstanding, so the count+outstanding gate reduces to !full
  assign imem_req = !reset && state == S_REQ && !full;
  assign imem_addr = pc;
  assign grant = imem_req && imem_gnt;
  assign push = state == S_WAIT && imem_rvalid && !redirect_valid;
  assign pop = if_valid && id_ready;
  assign din = '{pc: out_pc, instr: imem_rdata};
  assign if_valid = !empty;
  assign if_instr = empty ? NOP_INSTR : head.instr;
  assign if_pc = empty ? 32'h0 : head.pc;
  always_comb begin
    state_nx = state;
    pc_nx = grant ? pc + 32'd4 : pc;
    if (redirect_valid) begin
      pc_nx = redirect_target & ~32'd3;
      // A request still in flight after this cycle must have its data dropped
      state_nx = (outstanding && !imem_rvalid) || grant ? S_DISCARD : S_REQ;
    end else if (state == S_REQ)
      state_nx = grant ? S_WAIT : S_REQ;
    else if (imem_rvalid)
      state_nx = S_REQ;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_REQ;
      pc <= RESET_PC;
      out_pc <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      if (grant) out_pc <= pc;
    end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din(din),
    .dout(head),
    .empty(empty),
    .full(full)
  );
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) perf_fetch_count <= '0;
    else if (pop) perf_fetch_count <= perf_fetch_count + 32'd1;
`endif
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, prefetch buffer entries; legal values 2, 4 or 8.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req  out  1  instruction-memory request valid.
REQ-006 SHALL have port imem_addr  out  32  word-aligned fetch address, bits [1:0] always 00.
REQ-007 SHALL have port imem_gnt  in  1  memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid  in  1  read data valid; at least 1 cycle after the grant.
REQ-009 SHALL have port imem_rdata  in  32  instruction word.
REQ-010 SHALL have port redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-011 SHALL have port redirect_target  in  32  new PC; bits [1:0] ignored.
REQ-012 SHALL have port if_valid  out  1  instruction available to decode.
REQ-013 SHALL have port if_instr  out  32  instruction, feeding opcode [31:26] and funct [5:0] of decode.
REQ-014 SHALL have port if_pc  out  32  address of if_instr.
REQ-015 SHALL have port id_ready  in  1  decode consumes the instruction when if_valid and id_ready are both high.

Function
REQ-016 SHALL keep at most one memory request outstanding; outstanding means granted and not yet returned.
REQ-017 SHALL implement FSM S_REQ / S_WAIT / S_DISCARD.
- S_REQ: assert imem_req only when FIFO count + outstanding < FIFO_DEPTH.
- S_REQ to S_WAIT: on imem_gnt.
- S_WAIT to S_REQ: on imem_rvalid.
- S_DISCARD to S_REQ: on imem_rvalid, with the data dropped.
REQ-018 SHALL hold imem_req and imem_addr stable until imem_gnt, unless redirect_valid occurs.
REQ-019 SHALL advance the fetch PC by 4 on each grant, wrapping modulo 2^32.
REQ-020 SHALL push {fetch address, imem_rdata} into the FIFO on an accepted imem_rvalid; if_valid is high the following cycle (1-cycle latency).
REQ-021 SHALL drive if_instr and if_pc from the FIFO head; when the FIFO is empty, drive if_valid=0, if_instr=32'h0 (nop) and if_pc=0.
REQ-022 SHALL pop on if_valid && id_ready; id_ready with an empty FIFO has no effect.
REQ-023 SHALL never push when the FIFO is full; the request-gating rule guarantees this, and the verification environment asserts it.
REQ-024 SHALL handle push and pop in the same cycle with the count unchanged.
REQ-025 SHALL give redirect_valid priority over all other events in the same cycle, with these effects:
- FIFO flushed.
- if_valid low the next cycle.
- PC set to {redirect_target[31:2], 2'b00}.
REQ-026 SHALL set the FSM state on redirect as follows:
- Outstanding request, or grant in the same cycle: go to S_DISCARD.
- imem_rvalid in the same cycle: drop the data and go to S_REQ.
- Otherwise: go to S_REQ.
REQ-027 SHALL apply a further redirect during S_DISCARD by updating the PC and remaining in S_DISCARD.

Reset
REQ-028 SHALL, on reset, drive the following and hold them until reset deasserts:
- imem_req=0, imem_addr=RESET_PC.
- if_valid=0, if_instr=0, if_pc=0.
- FIFO empty, state S_REQ, PC=RESET_PC.
REQ-029 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-030 SHALL discard an in-flight memory response when reset asserts mid-operation; the memory is reset together with this block.

Configuration
REQ-031 SHALL, with FETCH_PERF_EN defined, add output perf_fetch_count [31:0] with this behaviour:
- Increments on each if_valid && id_ready.
- Wraps modulo 2^32.
- Reset to 0; unaffected by redirect.
REQ-032 SHALL, without FETCH_PERF_EN, omit the perf_fetch_count port and its counter entirely.

Structure
REQ-033 SHALL place the following in shared package fetch_pkg:
- RESET_PC default.
- NOP_INSTR (32'h0).
- FSM state type.
- FIFO entry type {pc[31:0], instr[31:0]}.
REQ-034 SHALL implement the buffer as sub-module fetch_fifo (parameterised depth, synchronous push/pop/flush, asynchronous reset).

Verification
REQ-035 SHALL cover the following directed scenarios (stimulus -> required response):
- Reset release, gnt=1, rvalid 1 cycle after each grant, id_ready=1 -> if_pc sequence 0x0, 0x4, 0x8; if_instr matches the memory image.
- id_ready=0 for 10 cycles, FIFO_DEPTH=2 -> exactly 2 grants then imem_req=0; FIFO full; no overflow.
- Redirect to 0x103 while a request to 0x8 is outstanding -> response for 0x8 dropped; next imem_addr=0x100; first if_pc=0x100.
- Redirect in the same cycle as imem_rvalid and a pop -> FIFO empty next cycle; if_valid=0; fetch restarts at the target.
- Fetch from 0xFFFF_FFFC -> next imem_addr=0x0000_0000.
- FETCH_PERF_EN defined, 5 consumed and 2 flushed instructions -> perf_fetch_count=5.
